sysbus_arbiter: RTL



---
 rtl/sysbus_pkg.sv | 16 +
 rtl/rr_pick.sv | 30 +++
 rtl/sysbus_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: arbiter state encoding and bus tag bits used by
// the bus masters.
package sysbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_OWNED   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    // Bit positions of the tag field carried on main_bus_req.
    localparam int SYSBUS_WRITE  = 0;
    localparam int SYSBUS_MEMORY = 1;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping at
// NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   winner,
    output logic [IDX_WIDTH-1:0] win_idx,
    output logic                 any
);

    logic [IDX_WIDTH-1:0] offset;
    logic [IDX_WIDTH:0]   sum;

    always_comb begin
        offset = '0;
        // Walk from the farthest position down so the closest hit to ptr wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) offset = IDX_WIDTH'(i);
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_WIDTH + 1)'(NUM_REQ)) sum = sum - (IDX_WIDTH + 1)'(NUM_REQ);
        win_idx = sum[IDX_WIDTH-1:0];
        any     = |req;
        winner  = any ? (NUM_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin owner arbiter for the shared system bus: grants, tracks the owner
// through its tenure, inserts one turnaround cycle and revokes untaken grants.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int IDX_WIDTH     = 2,
    parameter int GRANT_TIMEOUT = 15,
    parameter int TIMEOUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   abtr_reqcyc,
    input  logic [NUM_REQ-1:0]   bus_busy,
    output logic [NUM_REQ-1:0]   abtr_grant,
    output logic [IDX_WIDTH-1:0] owner_idx,
    output logic                 owner_valid,
    output logic                 bus_idle,
    output logic                 grant_timeout,
    output logic                 busy_err,
    output arb_state_e           dbg_state
);

    // Handshake: a master holds abtr_reqcyc until it sees abtr_grant, then raises
    // bus_busy for as long as it drives the bus; the grant stays up while that
    // owner's bus_busy is high and is withdrawn one cycle after it falls. A grant
    // whose request drops, or that is not taken within GRANT_TIMEOUT cycles, is
    // revoked.

    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST = TIMEOUT_WIDTH'(GRANT_TIMEOUT - 1);

    arb_state_e             state;
    logic [IDX_WIDTH-1:0]   rr_ptr;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;

    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic                   pick_any;
    logic [IDX_WIDTH-1:0]   next_ptr;
    logic [NUM_REQ-1:0]     owner_mask;
    logic                   owner_busy;
    logic                   owner_req;
    logic                   go_release;
    logic                   timeout_hit;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .IDX_WIDTH(IDX_WIDTH)
    ) u_rr_pick (
        .req    (abtr_reqcyc),
        .ptr    (rr_ptr),
        .winner (pick_onehot),
        .win_idx(pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        next_ptr    = (int'(owner_idx) == NUM_REQ - 1) ? '0 : owner_idx + IDX_WIDTH'(1);
        owner_mask  = owner_valid ? (NUM_REQ'(1) << owner_idx) : '0;
        owner_busy  = bus_busy[owner_idx];
        owner_req   = abtr_reqcyc[owner_idx];
        timeout_hit = 1'b0;
        go_release  = 1'b0;
        // Busy beats withdraw, withdraw beats timeout.
        if (state == ST_GRANT && !owner_busy) begin
            if (!owner_req) begin
                go_release = 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
                go_release  = 1'b1;
                timeout_hit = 1'b1;
            end
        end else if (state == ST_OWNED && !owner_busy) begin
            go_release = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            abtr_grant    <= '0;
            owner_idx     <= '0;
            owner_valid   <= 1'b0;
            bus_idle      <= 1'b1;
            grant_timeout <= 1'b0;
            busy_err      <= 1'b0;
            rr_ptr        <= '0;
            wait_cnt      <= '0;
        end else begin
            grant_timeout <= timeout_hit;
            busy_err      <= |(bus_busy & ~owner_mask);
            if (go_release) begin
                // rr_ptr moves now so the turnaround cycle arbitrates with it.
                state       <= ST_RELEASE;
                abtr_grant  <= '0;
                owner_valid <= 1'b0;
                rr_ptr      <= next_ptr;
            end else begin
                case (state)
                    ST_IDLE, ST_RELEASE: begin
                        if (pick_any) begin
                            state       <= ST_GRANT;
                            abtr_grant  <= pick_onehot;
                            owner_idx   <= pick_idx;
                            owner_valid <= 1'b1;
                            bus_idle    <= 1'b0;
                            wait_cnt    <= '0;
                        end else begin
                            state    <= ST_IDLE;
                            bus_idle <= 1'b1;
                        end
                    end
                    ST_GRANT: begin
                        if (owner_busy) state <= ST_OWNED;
                        else            wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
                    end
                    default: state <= ST_OWNED;
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule
